// File: rtl/d_cache_ctrl.sv
// d_cache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// It sits between the MEM stage and a line-wide memory port. Hits complete in the
// request cycle. Misses stall the pipeline while the controller runs an optional
// victim write-back, then a line fill, then a one-cycle response.
module d_cache_ctrl #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cpu_read,
  input  logic                            cpu_write,
  input  logic [WORD_SIZE-1:0]            cpu_addr,
  input  logic [WORD_SIZE-1:0]            cpu_wdata,
  output logic [WORD_SIZE-1:0]            cpu_rdata,
  output logic                            d_cache_hit,
  output logic                            d_ready,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
  input  logic                            mem_done,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count
);

  localparam int OFF_W = 2;
  localparam int IDX_W = 2;
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FILL,
    S_RESP
  } state_t;

  state_t                          r_state;

  // Per-line storage
  logic [NUM_LINES-1:0]            r_valid;
  logic [NUM_LINES-1:0]            r_dirty;
  logic [TAG_W-1:0]                r_tag  [NUM_LINES];
  logic [WORD_SIZE-1:0]            r_data [NUM_LINES][LINE_WORDS];

  // Index and tag of the access being serviced by a miss
  logic [IDX_W-1:0]                r_lat_idx;
  logic [TAG_W-1:0]                r_lat_tag;

  // Registered memory-side and handshake outputs
  logic                            r_mem_read;
  logic                            r_mem_write;
  logic                            r_d_ready;
  logic [WORD_SIZE-1:0]            r_mem_addr;
  logic [WORD_SIZE*LINE_WORDS-1:0] r_mem_wdata;

  logic [15:0]                     r_hit_count;
  logic [15:0]                     r_miss_count;

  logic                            w_req;
  logic                            w_is_read;
  logic [OFF_W-1:0]                w_off;
  logic [IDX_W-1:0]                w_idx;
  logic [TAG_W-1:0]                w_tag;
  logic                            w_idle;
  logic                            w_tag_match;
  logic                            w_hit_access;
  logic                            w_miss;
  logic                            w_victim_dirty;
  logic [WORD_SIZE*LINE_WORDS-1:0] w_victim_line;

  // A request with both strobes high is treated as a store
  assign w_req     = cpu_read | cpu_write;
  assign w_is_read = cpu_read & ~cpu_write;

  assign w_off = cpu_addr[OFF_W-1:0];
  assign w_idx = cpu_addr[OFF_W +: IDX_W];
  assign w_tag = cpu_addr[WORD_SIZE-1 -: TAG_W];

  assign w_idle         = (r_state == S_IDLE);
  assign w_tag_match    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit_access   = w_idle & w_req & w_tag_match;
  assign w_miss         = w_idle & w_req & ~w_tag_match;
  assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];

  // A cycle with no request never stalls; outside IDLE the pipeline is held
  assign d_cache_hit = w_idle & (~w_req | w_tag_match);

  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign d_ready    = r_d_ready;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  // Pack the line currently selected by the request index, word 0 in the low bits
  always_comb begin
    w_victim_line = '0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      w_victim_line[k*WORD_SIZE +: WORD_SIZE] = r_data[w_idx][k];
    end
  end

  // Load data: the hit word in IDLE, or the word from the freshly filled line in RESP
  always_comb begin
    cpu_rdata = '0;
    if (w_idle && w_is_read && w_tag_match) begin
      cpu_rdata = r_data[w_idx][w_off];
    end else if ((r_state == S_RESP) && w_is_read) begin
      cpu_rdata = r_data[r_lat_idx][w_off];
    end
  end

  // Miss sequencing FSM with registered memory requests and the d_ready pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_lat_idx   <= '0;
      r_lat_tag   <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_d_ready   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_lat_idx <= w_idx;
            r_lat_tag <= w_tag;
            if (w_victim_dirty) begin
              r_state     <= S_WRITEBACK;
              r_mem_write <= 1'b1;
              r_mem_addr  <= {r_tag[w_idx], w_idx, 2'b00};
              r_mem_wdata <= w_victim_line;
            end else begin
              r_state    <= S_FILL;
              r_mem_read <= 1'b1;
              r_mem_addr <= {w_tag, w_idx, 2'b00};
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_done) begin
            r_state     <= S_FILL;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_addr  <= {r_lat_tag, r_lat_idx, 2'b00};
            r_mem_wdata <= '0;
          end
        end
        S_FILL: begin
          if (mem_done) begin
            r_state    <= S_RESP;
            r_mem_read <= 1'b0;
            r_d_ready  <= 1'b1;
            r_mem_addr <= '0;
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          r_d_ready <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_d_ready   <= 1'b0;
        end
      endcase
    end
  end

  // Line storage: store hits, fill loads, and the deferred store of a write miss
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_dirty <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        r_tag[i] <= '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
          r_data[i][k] <= '0;
        end
      end
    end else begin
      if (w_hit_access && cpu_write) begin
        r_data[w_idx][w_off] <= cpu_wdata;
        r_dirty[w_idx]       <= 1'b1;
      end else if ((r_state == S_FILL) && mem_done) begin
        for (int k = 0; k < LINE_WORDS; k++) begin
          r_data[r_lat_idx][k] <= mem_rdata[k*WORD_SIZE +: WORD_SIZE];
        end
        r_valid[r_lat_idx] <= 1'b1;
        r_dirty[r_lat_idx] <= 1'b0;
        r_tag[r_lat_idx]   <= r_lat_tag;
      end else if ((r_state == S_RESP) && cpu_write) begin
        r_data[r_lat_idx][w_off] <= cpu_wdata;
        r_dirty[r_lat_idx]       <= 1'b1;
      end
    end
  end

  // Saturating performance counters; only IDLE accesses with a request count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_access && (r_hit_count != 16'hFFFF)) begin
        r_hit_count <= r_hit_count + 16'd1;
      end
      if (w_miss && (r_miss_count != 16'hFFFF)) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// tb_d_cache_ctrl: directed self-checking bench for d_cache_ctrl.
module tb_d_cache_ctrl;

  logic        clk;
  logic        reset_n;
  logic        cpu_read;
  logic        cpu_write;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        d_cache_hit;
  logic        d_ready;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_done;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int numCompared   = 0;
  int numMismatched = 0;

  d_cache_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .d_cache_hit (d_cache_hit),
    .d_ready     (d_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_done    (mem_done),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [15:0] wdata);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a full miss: optional write-back, fill, response; mem_done answers at once
  task automatic doMiss(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic expWb,
                        input logic [15:0] wbAddr, input logic [63:0] wbData,
                        input logic [15:0] fillAddr, input logic [63:0] fillData,
                        input logic [15:0] expRdata);
    applyStimulus(rd, wr, addr, wdata);
    #1;
    checkOutput("miss_hit", d_cache_hit, 0);
    tick();
    if (expWb) begin
      checkOutput("wb_write", mem_write, 1);
      checkOutput("wb_read",  mem_read, 0);
      checkOutput("wb_addr",  mem_addr, wbAddr);
      checkOutput("wb_data",  mem_wdata, wbData);
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
    end
    checkOutput("fill_read",  mem_read, 1);
    checkOutput("fill_write", mem_write, 0);
    checkOutput("fill_addr",  mem_addr, fillAddr);
    checkOutput("fill_hit",   d_cache_hit, 0);
    mem_done  = 1'b1;
    mem_rdata = fillData;
    tick();
    mem_done = 1'b0;
    checkOutput("resp_ready", d_ready, 1);
    checkOutput("resp_read",  mem_read, 0);
    if (rd && !wr) checkOutput("resp_rdata", cpu_rdata, expRdata);
    tick();
    checkOutput("idle_ready", d_ready, 0);
    applyStimulus(0, 0, 16'h0000, 16'h0000);
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_done  = 1'b0;
    mem_rdata = '0;
    applyStimulus(0, 0, 16'h0000, 16'h0000);

    // Reset values
    #12;
    checkOutput("rst_hit",    d_cache_hit, 1);
    checkOutput("rst_mrd",    mem_read, 0);
    checkOutput("rst_mwr",    mem_write, 0);
    checkOutput("rst_ready",  d_ready, 0);
    checkOutput("rst_hits",   hit_count, 0);
    checkOutput("rst_misses", miss_count, 0);
    checkOutput("rst_maddr",  mem_addr, 0);
    checkOutput("rst_mwdata", mem_wdata, 0);
    checkOutput("rst_rdata",  cpu_rdata, 0);
    reset_n = 1'b1;
    tick();

    // Clean read miss to 0x0010, mem_done two cycles into FILL
    applyStimulus(1, 0, 16'h0010, 16'h0000);
    #1;
    checkOutput("c0_hit", d_cache_hit, 0);
    tick();
    checkOutput("c1_mrd",   mem_read, 1);
    checkOutput("c1_addr",  mem_addr, 16'h0010);
    checkOutput("c1_mwr",   mem_write, 0);
    tick();
    checkOutput("c2_mrd", mem_read, 1);
    mem_done  = 1'b1;
    mem_rdata = 64'h0004_0003_0002_0001;
    tick();
    mem_done = 1'b0;
    checkOutput("c3_ready", d_ready, 1);
    checkOutput("c3_rdata", cpu_rdata, 16'h0001);
    checkOutput("c3_mrd",   mem_read, 0);
    tick();

    // Read hit right after the fill
    applyStimulus(1, 0, 16'h0012, 16'h0000);
    #1;
    checkOutput("h1_hit",    d_cache_hit, 1);
    checkOutput("h1_rdata",  cpu_rdata, 16'h0003);
    checkOutput("h1_ready",  d_ready, 0);
    checkOutput("h1_mrd",    mem_read, 0);
    checkOutput("h1_misses", miss_count, 1);
    tick();
    checkOutput("h1_hits", hit_count, 1);
    checkOutput("h1_mrd2", mem_read, 0);

    // Store hit, then a conflicting read that forces a write-back
    applyStimulus(0, 1, 16'h0011, 16'hBEEF);
    #1;
    checkOutput("w1_hit", d_cache_hit, 1);
    tick();
    checkOutput("w1_hits", hit_count, 2);
    doMiss(1, 0, 16'h0051, 16'h0000, 1, 16'h0010, 64'h0004_0003_BEEF_0001,
           16'h0050, 64'h0008_0007_0006_0005, 16'h0006);

    // Write miss allocates, then the stored word reads back
    doMiss(0, 1, 16'h0020, 16'h1234, 0, 16'h0000, 64'h0,
           16'h0020, 64'h1111_2222_3333_4444, 16'h0000);
    applyStimulus(1, 0, 16'h0020, 16'h0000);
    #1;
    checkOutput("wm_hit",   d_cache_hit, 1);
    checkOutput("wm_rdata", cpu_rdata, 16'h1234);
    tick();

    // Evicting the written line must write it back with the stored word
    doMiss(1, 0, 16'h0060, 16'h0000, 1, 16'h0020, 64'h1111_2222_3333_1234,
           16'h0060, 64'hAAAA_BBBB_CCCC_DDDD, 16'hDDDD);
    checkOutput("sum_hits",   hit_count, 3);
    checkOutput("sum_misses", miss_count, 4);

    // Reset pulse in the middle of a fill
    applyStimulus(1, 0, 16'h0034, 16'h0000);
    #1;
    checkOutput("r_hit0", d_cache_hit, 0);
    tick();
    checkOutput("r_mrd_before", mem_read, 1);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("r_mrd_async", mem_read, 0);
    checkOutput("r_ready",     d_ready, 0);
    checkOutput("r_misses",    miss_count, 0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    checkOutput("r_ready2", d_ready, 0);
    checkOutput("r_rehit",  d_cache_hit, 0);
    doMiss(1, 0, 16'h0034, 16'h0000, 0, 16'h0000, 64'h0,
           16'h0034, 64'h0044_0033_0022_0011, 16'h0011);
    checkOutput("r_misses2", miss_count, 1);

    // Old contents were invalidated by the reset
    applyStimulus(1, 0, 16'h0060, 16'h0000);
    #1;
    checkOutput("r_inval", d_cache_hit, 0);
    applyStimulus(0, 0, 16'h0000, 16'h0000);
    #1;

    // Idle cycles with mem_done toggling change nothing
    for (int i = 0; i < 4; i++) begin
      mem_done = ~mem_done;
      tick();
      checkOutput("idle_hit",   d_cache_hit, 1);
      checkOutput("idle_mrd",   mem_read, 0);
      checkOutput("idle_mwr",   mem_write, 0);
      checkOutput("idle_ready", d_ready, 0);
    end
    mem_done = 1'b0;
    checkOutput("idle_hits",   hit_count, 0);
    checkOutput("idle_misses", miss_count, 1);

    // Long run of hits saturates the hit counter
    applyStimulus(1, 0, 16'h0034, 16'h0000);
    #1;
    checkOutput("sat_hit",   d_cache_hit, 1);
    checkOutput("sat_rdata", cpu_rdata, 16'h0011);
    for (int i = 0; i < 65540; i++) begin
      tick();
    end
    checkOutput("sat_hits",   hit_count, 16'hFFFF);
    checkOutput("sat_misses", miss_count, 1);
    applyStimulus(0, 0, 16'h0000, 16'h0000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
